// File: rtl/uart_cfg_parser_if.sv
// rtl/uart_cfg_parser_if.sv - received-byte strobe bundle from the UART receiver
interface uart_cfg_parser_if;
   logic       Rx_DV;
   logic [7:0] Rx_Byte;

   modport master (output Rx_DV, output Rx_Byte);
   modport slave  (input  Rx_DV, input  Rx_Byte);
endinterface

// File: rtl/uart_cfg_parser.sv
// rtl/uart_cfg_parser.sv - frames sync/addr/data/chk packets into config register writes
module uart_cfg_parser #(
   parameter int         NUM_REGS     = 16,
   parameter int         TIMEOUT_CLKS = 100000,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   uart_cfg_parser_if.slave      rx,
   output logic [NUM_REGS*8-1:0] o_Regs,
   output logic                  o_Wr_Pulse,
   output logic [7:0]            o_Wr_Addr,
   output logic [7:0]            o_Wr_Data,
   output logic                  o_Err_Pulse,
   output logic [1:0]            o_Err_Code,
   output logic [7:0]            o_Err_Count,
   output logic                  o_Busy
);
   localparam int            CW         = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CLKS - 2);
   localparam logic [8:0]    NUM_REGS_W = 9'(NUM_REGS);

   typedef enum logic [1:0] {S_SYNC, S_ADDR, S_DATA, S_CHK} state_t;

   state_t        state;
   logic [CW-1:0] to_cnt;
   logic [7:0]    addr;
   logic [7:0]    data;

   logic       dv;
   logic [7:0] rx_byte;
   logic [7:0] chk_exp;
   logic       addr_ok;
   logic       timeout_hit;
   logic       chk_bad;
   logic       range_bad;
   logic       commit;
   logic       err_hit;
   logic [1:0] err_code_nxt;

   assign dv      = rx.Rx_DV;
   assign rx_byte = rx.Rx_Byte;
   assign chk_exp = addr + data;
   assign addr_ok = {1'b0, addr} < NUM_REGS_W;

   // The counter would reach TIMEOUT_CLKS-1 at this edge; a DV arriving now wins.
   assign timeout_hit  = (state != S_SYNC) && !dv && (to_cnt == TO_LAST);
   assign chk_bad      = (state == S_CHK) && dv && (rx_byte != chk_exp);
   assign range_bad    = (state == S_CHK) && dv && (rx_byte == chk_exp) && !addr_ok;
   assign commit       = (state == S_CHK) && dv && (rx_byte == chk_exp) && addr_ok;
   assign err_hit      = timeout_hit || chk_bad || range_bad;
   assign err_code_nxt = timeout_hit ? 2'b11 : (chk_bad ? 2'b01 : 2'b10);

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state       <= S_SYNC;
         to_cnt      <= '0;
         addr        <= '0;
         data        <= '0;
         o_Regs      <= '0;
         o_Wr_Pulse  <= 1'b0;
         o_Wr_Addr   <= '0;
         o_Wr_Data   <= '0;
         o_Err_Pulse <= 1'b0;
         o_Err_Code  <= '0;
         o_Err_Count <= '0;
         o_Busy      <= 1'b0;
      end else begin
         o_Wr_Pulse  <= commit;
         o_Err_Pulse <= err_hit;

         if (err_hit) begin
            o_Err_Code <= err_code_nxt;
            if (o_Err_Count != 8'hFF)
               o_Err_Count <= o_Err_Count + 8'd1;
         end

         if (commit) begin
            o_Wr_Addr <= addr;
            o_Wr_Data <= data;
            for (int n = 0; n < NUM_REGS; n++)
               if (addr == 8'(n))
                  o_Regs[8*n +: 8] <= data;
         end

         if (dv || (state == S_SYNC) || timeout_hit)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 1'b1;

         if (timeout_hit) begin
            state  <= S_SYNC;
            o_Busy <= 1'b0;
         end else if (dv) begin
            case (state)
               S_SYNC: begin
                  if (rx_byte == SYNC_BYTE) begin
                     state  <= S_ADDR;
                     o_Busy <= 1'b1;
                  end
               end
               S_ADDR: begin
                  addr  <= rx_byte;
                  state <= S_DATA;
               end
               S_DATA: begin
                  data  <= rx_byte;
                  state <= S_CHK;
               end
               default: begin
                  state  <= S_SYNC;
                  o_Busy <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_cfg_parser.sv
// tb/tb_uart_cfg_parser.sv - table vectors, corner sequences and random packets vs a packet-level model
module tb_uart_cfg_parser;
   localparam int         NUM_REGS = 16;
   localparam int         TO_CLKS  = 12;
   localparam logic [7:0] SYNC     = 8'hA5;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_REGS*8-1:0] o_Regs;
   logic                  o_Wr_Pulse;
   logic [7:0]            o_Wr_Addr;
   logic [7:0]            o_Wr_Data;
   logic                  o_Err_Pulse;
   logic [1:0]            o_Err_Code;
   logic [7:0]            o_Err_Count;
   logic                  o_Busy;

   uart_cfg_parser_if rx_if ();

   uart_cfg_parser #(
      .NUM_REGS     (NUM_REGS),
      .TIMEOUT_CLKS (TO_CLKS),
      .SYNC_BYTE    (SYNC)
   ) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .rx          (rx_if.slave),
      .o_Regs      (o_Regs),
      .o_Wr_Pulse  (o_Wr_Pulse),
      .o_Wr_Addr   (o_Wr_Addr),
      .o_Wr_Data   (o_Wr_Data),
      .o_Err_Pulse (o_Err_Pulse),
      .o_Err_Code  (o_Err_Code),
      .o_Err_Count (o_Err_Count),
      .o_Busy      (o_Busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Packet-level reference: a flag for "inside a packet", the payload bytes so far, idle cycles.
   bit                    m_in_pkt;
   int                    m_q[$];
   int                    m_idle;
   logic [NUM_REGS*8-1:0] m_regs;
   bit                    m_wr_pulse;
   int                    m_wr_addr;
   int                    m_wr_data;
   bit                    m_err_pulse;
   int                    m_err_code;
   int                    m_err_cnt;

   function automatic void model_reset();
      m_in_pkt = 0; m_q.delete(); m_idle = 0; m_regs = '0;
      m_wr_pulse = 0; m_wr_addr = 0; m_wr_data = 0;
      m_err_pulse = 0; m_err_code = 0; m_err_cnt = 0;
   endfunction

   function automatic void model_err(input int code);
      m_err_pulse = 1;
      m_err_code  = code;
      if (m_err_cnt < 255) m_err_cnt++;
      m_in_pkt = 0;
   endfunction

   function automatic void model_step(input bit dv, input int b);
      m_wr_pulse  = 0;
      m_err_pulse = 0;
      if (!m_in_pkt) begin
         if (dv && b == SYNC) begin
            m_in_pkt = 1; m_q.delete(); m_idle = 0;
         end
      end else if (dv) begin
         m_q.push_back(b);
         m_idle = 0;
         if (m_q.size() == 3) begin
            if (((m_q[0] + m_q[1]) % 256) != m_q[2]) model_err(1);
            else if (m_q[0] >= NUM_REGS) model_err(2);
            else begin
               m_regs[8*m_q[0] +: 8] = 8'(m_q[1]);
               m_wr_pulse = 1; m_wr_addr = m_q[0]; m_wr_data = m_q[1];
               m_in_pkt = 0;
            end
         end
      end else begin
         m_idle++;
         if (m_idle == TO_CLKS - 1) model_err(3);
      end
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("regs",      128'(o_Regs),      128'(m_regs));
      chk("wr_pulse",  128'(o_Wr_Pulse),  128'(m_wr_pulse));
      chk("wr_addr",   128'(o_Wr_Addr),   128'(m_wr_addr));
      chk("wr_data",   128'(o_Wr_Data),   128'(m_wr_data));
      chk("err_pulse", 128'(o_Err_Pulse), 128'(m_err_pulse));
      chk("err_code",  128'(o_Err_Code),  128'(m_err_code));
      chk("err_count", 128'(o_Err_Count), 128'(m_err_cnt));
      chk("busy",      128'(o_Busy),      128'(m_in_pkt));
   endtask

   task automatic cycle(input bit dv, input logic [7:0] b);
      rx_if.Rx_DV   = dv;
      rx_if.Rx_Byte = b;
      @(posedge clk);
      model_step(dv, int'(b));
      #1;
      chk_model();
      rx_if.Rx_DV = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 8'($urandom));
   endtask

   typedef struct {
      logic [7:0] b [4];
      bit         exp_wr;
      bit         exp_err;
      logic [1:0] exp_code;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{b: '{8'hA5, 8'h03, 8'h5C, 8'h5F}, exp_wr: 1, exp_err: 0, exp_code: 2'b00};
      vecs[1] = '{b: '{8'hA5, 8'h02, 8'h10, 8'h13}, exp_wr: 0, exp_err: 1, exp_code: 2'b01};
      vecs[2] = '{b: '{8'hA5, 8'h10, 8'h01, 8'h11}, exp_wr: 0, exp_err: 1, exp_code: 2'b10};
      vecs[3] = '{b: '{8'hA5, 8'h0F, 8'hFF, 8'h0E}, exp_wr: 1, exp_err: 0, exp_code: 2'b00};
      vecs[4] = '{b: '{8'hA5, 8'hFF, 8'h00, 8'hFF}, exp_wr: 0, exp_err: 1, exp_code: 2'b10};
      vecs[5] = '{b: '{8'hA5, 8'h00, 8'hA5, 8'hA5}, exp_wr: 1, exp_err: 0, exp_code: 2'b00};
      vecs[6] = '{b: '{8'hA5, 8'h07, 8'hFA, 8'h01}, exp_wr: 1, exp_err: 0, exp_code: 2'b00};

      model_reset();
      rx_if.Rx_DV   = 1'b0;
      rx_if.Rx_Byte = 8'h00;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_model();
      rst = 1'b0;

      // Back-to-back packets, no dead cycles between them.
      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < 4; j++) send(vecs[i].b[j]);
         chk("tbl_wr_pulse",  128'(o_Wr_Pulse),  128'(vecs[i].exp_wr));
         chk("tbl_err_pulse", 128'(o_Err_Pulse), 128'(vecs[i].exp_err));
         if (vecs[i].exp_err) chk("tbl_err_code", 128'(o_Err_Code), 128'(vecs[i].exp_code));
         if (i == 0) begin
            chk("first_regs",  128'(o_Regs),    128'h5C << 24);
            chk("first_waddr", 128'(o_Wr_Addr), 128'd3);
         end
      end
      idle(2);
      chk("busy_idle", 128'(o_Busy), 128'd0);

      // Junk outside a packet is dropped with no error.
      send(8'h00);
      chk("junk0_err", 128'(o_Err_Pulse), 128'd0);
      send(8'hFF);
      chk("junk1_busy", 128'(o_Busy), 128'd0);
      send(8'hA5); send(8'h0F); send(8'h11); send(8'h20);
      chk("junk_then_wr", 128'(o_Regs[127:120]), 128'h11);

      // Timeout exactly TO_CLKS-1 idle clocks after the last DV.
      send(8'hA5); send(8'h04);
      for (int i = 1; i <= TO_CLKS - 1; i++) begin
         cycle(1'b0, 8'h00);
         if (i < TO_CLKS - 1) begin
            chk("to_wait_err", 128'(o_Err_Pulse), 128'd0);
            chk("to_wait_busy", 128'(o_Busy), 128'd1);
         end else begin
            chk("to_fire_err",  128'(o_Err_Pulse), 128'd1);
            chk("to_fire_code", 128'(o_Err_Code),  128'd3);
            chk("to_fire_busy", 128'(o_Busy),      128'd0);
         end
      end

      // DV landing on the threshold cycle wins over the timeout.
      send(8'hA5); send(8'h02);
      idle(TO_CLKS - 2);
      send(8'h33);
      chk("thr_no_err", 128'(o_Err_Pulse), 128'd0);
      chk("thr_busy",   128'(o_Busy),      128'd1);
      send(8'h35);
      chk("thr_commit", 128'(o_Wr_Pulse),  128'd1);

      // Asynchronous reset mid-packet.
      send(8'hA5); send(8'h01);
      rst = 1'b1;
      #2;
      model_reset();
      chk_model();
      chk("rst_busy", 128'(o_Busy), 128'd0);
      #1;
      rst = 1'b0;
      idle(2);
      chk("post_rst_pulse", 128'({o_Wr_Pulse, o_Err_Pulse}), 128'd0);

      // Error counter saturation.
      for (int p = 0; p < 256; p++) begin
         send(8'hA5); send(8'h02); send(8'h10); send(8'h13);
      end
      chk("err_sat", 128'(o_Err_Count), 128'd255);

      // Random traffic against the model, counter cleared first.
      rst = 1'b1;
      #2;
      model_reset();
      #1;
      rst = 1'b0;
      for (int p = 0; p < 300; p++) begin
         logic [7:0] a, d, c;
         int         len;
         if ($urandom_range(0, 3) == 0) send(8'($urandom));
         a   = 8'($urandom_range(0, 20));
         d   = 8'($urandom);
         c   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : a + d;
         len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 4;
         for (int j = 0; j < len; j++) begin
            case (j)
               0: send(SYNC);
               1: send(a);
               2: send(d);
               default: send(c);
            endcase
            if ($urandom_range(0, 19) == 0) idle($urandom_range(TO_CLKS - 3, TO_CLKS + 1));
            else if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
         if (len < 4) idle(TO_CLKS);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
